// File: rtl/al_pkg.sv
// Shared types, limits and BCD helpers for the alarm clock core.
package al_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t h_ms;
        bcd_digit_t h_ls;
        bcd_digit_t m_ms;
        bcd_digit_t m_ls;
    } hhmm_t;

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} al_state_t;

    localparam logic [7:0] MAX_HOUR_BCD = 8'h23;
    localparam logic [7:0] MAX_MIN_BCD  = 8'h59;

    // Once every digit is known to be 0..9, a plain 8-bit compare orders BCD pairs correctly.
    function automatic logic is_valid_hhmm(input hhmm_t v);
        logic digits_ok;
        digits_ok = (v.h_ms <= 4'd9) && (v.h_ls <= 4'd9) &&
                    (v.m_ms <= 4'd9) && (v.m_ls <= 4'd9);
        return digits_ok && ({v.m_ms, v.m_ls} <= MAX_MIN_BCD) &&
               ({v.h_ms, v.h_ls} <= MAX_HOUR_BCD);
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v, input logic wrap);
        if (wrap)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/al_bcd_timecount.sv
// Time-of-day counter in BCD (hh:mm:ss) with a load port and a minute strobe
// that is high the cycle the seconds read 00 after a wrap.
module al_bcd_timecount
    import al_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        i_tick,
    input  logic        i_load,
    input  hhmm_t       i_load_value,
    output hhmm_t       o_hhmm,
    output logic [7:0]  o_sec,
    output logic        o_minute_edge
);

    hhmm_t      r_hhmm;
    logic [7:0] r_sec;
    logic       r_minute_edge;

    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hour_wrap;

    assign w_sec_wrap  = (r_sec == MAX_MIN_BCD);
    assign w_min_wrap  = ({r_hhmm.m_ms, r_hhmm.m_ls} == MAX_MIN_BCD);
    assign w_hour_wrap = ({r_hhmm.h_ms, r_hhmm.h_ls} == MAX_HOUR_BCD);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_hhmm        <= '0;
            r_sec         <= 8'h00;
            r_minute_edge <= 1'b0;
        end else begin
            r_minute_edge <= 1'b0;
            if (i_load) begin
                r_hhmm <= i_load_value;
                r_sec  <= 8'h00;
            end else if (i_tick) begin
                r_sec <= bcd2_inc(r_sec, w_sec_wrap);
                if (w_sec_wrap) begin
                    r_minute_edge <= 1'b1;
                    {r_hhmm.m_ms, r_hhmm.m_ls} <= bcd2_inc({r_hhmm.m_ms, r_hhmm.m_ls}, w_min_wrap);
                    if (w_min_wrap)
                        {r_hhmm.h_ms, r_hhmm.h_ls} <= bcd2_inc({r_hhmm.h_ms, r_hhmm.h_ls}, w_hour_wrap);
                end
            end
        end
    end

    assign o_hhmm        = r_hhmm;
    assign o_sec         = r_sec;
    assign o_minute_edge = r_minute_edge;

endmodule

// File: rtl/al_alarm_core.sv
// Alarm clock core: BCD time keeping, NUM_ALARMS setpoints and ring/snooze FSM.
// Define AL_HOUR12_EN for 12-hour presentation with pm flag (one extra cycle of latency).
module al_alarm_core
    import al_pkg::*;
#(
    parameter int NUM_ALARMS = 2,
    parameter int SNOOZE_MIN = 9,
    parameter int RING_MIN   = 5
) (
    input  logic                                            mclk,
    input  logic                                            rst,
    input  logic                                            sec_tick,
    input  logic                                            set_time,
    input  logic                                            set_alarm,
    input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] set_sel,
    input  logic [15:0]                                     set_value,
    input  logic [NUM_ALARMS-1:0]                           alarm_en,
    input  logic                                            snooze,
    input  logic                                            alarm_off,
    output logic [15:0]                                     time_bcd,
    output logic [7:0]                                      sec_bcd,
    output logic                                            pm,
    output logic                                            ringing,
    output logic [NUM_ALARMS-1:0]                           ring_src,
    output logic                                            set_err
);

    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int CNT_W = 6;

    logic                  w_value_ok;
    logic                  w_sel_ok;
    logic                  w_time_wr;
    logic                  w_alarm_wr;
    logic                  w_reject;
    hhmm_t                 w_hhmm;
    logic [7:0]            w_sec;
    logic                  w_minute_edge;
    logic [NUM_ALARMS-1:0] w_match;
    logic [NUM_ALARMS-1:0] w_first;
    logic                  w_src_lost;

    al_state_t             r_state;
    logic [NUM_ALARMS-1:0] r_ring_src;
    logic [CNT_W-1:0]      r_ring_cnt;
    logic [CNT_W-1:0]      r_snz_cnt;
    logic                  r_ringing;
    logic                  r_set_err;

    assign w_value_ok = is_valid_hhmm(set_value);
    assign w_sel_ok   = int'(set_sel) < NUM_ALARMS;
    assign w_time_wr  = set_time & w_value_ok;
    assign w_alarm_wr = set_alarm & w_value_ok & w_sel_ok;
    assign w_reject   = (set_time & ~w_value_ok) | (set_alarm & ~(w_value_ok & w_sel_ok));

    // A tick arriving with set_time is dropped even if the load itself is rejected.
    al_bcd_timecount u_timecount (
        .clk           (mclk),
        .srst          (rst),
        .i_tick        (sec_tick & ~set_time),
        .i_load        (w_time_wr),
        .i_load_value  (set_value),
        .o_hhmm        (w_hhmm),
        .o_sec         (w_sec),
        .o_minute_edge (w_minute_edge)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
            hhmm_t r_alarm;
            always_ff @(posedge mclk) begin
                if (rst)
                    r_alarm <= '0;
                else if (w_alarm_wr && (set_sel == SEL_W'(gi)))
                    r_alarm <= set_value;
            end
            assign w_match[gi] = alarm_en[gi] && (r_alarm == w_hhmm);
        end
    endgenerate

    // Isolate the lowest set bit so the lowest-indexed alarm wins.
    assign w_first    = w_match & (~w_match + NUM_ALARMS'(1));
    assign w_src_lost = ~|(alarm_en & r_ring_src);

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ring_src <= '0;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_ringing  <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            r_set_err <= w_reject;
            case (r_state)
                IDLE: begin
                    if (w_minute_edge && |w_match) begin
                        r_state    <= RING;
                        r_ring_src <= w_first;
                        r_ring_cnt <= '0;
                        r_ringing  <= 1'b1;
                    end
                end
                RING: begin
                    if (w_src_lost || alarm_off) begin
                        r_state    <= IDLE;
                        r_ring_src <= '0;
                        r_ringing  <= 1'b0;
                    end else if (snooze) begin
                        r_state   <= SNOOZE;
                        r_snz_cnt <= '0;
                        r_ringing <= 1'b0;
                    end else if (w_minute_edge) begin
                        if (r_ring_cnt == CNT_W'(RING_MIN - 1)) begin
                            r_state    <= IDLE;
                            r_ring_src <= '0;
                            r_ringing  <= 1'b0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt + CNT_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (w_src_lost || alarm_off) begin
                        r_state    <= IDLE;
                        r_ring_src <= '0;
                    end else if (w_minute_edge) begin
                        if (r_snz_cnt == CNT_W'(SNOOZE_MIN - 1)) begin
                            r_state    <= RING;
                            r_ring_cnt <= '0;
                            r_ringing  <= 1'b1;
                        end else begin
                            r_snz_cnt <= r_snz_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_ring_src <= '0;
                    r_ringing  <= 1'b0;
                end
            endcase
        end
    end

    assign ringing  = r_ringing;
    assign ring_src = r_ring_src;
    assign set_err  = r_set_err;

`ifdef AL_HOUR12_EN
    hhmm_t      r_time_out;
    logic [7:0] r_sec_out;
    logic       r_pm;
    logic [7:0] w_hh;

    // 00 shows as 12; 13..19 drop 12 directly, 20..23 map to 08..11.
    function automatic logic [7:0] hour12(input logic [7:0] h);
        if (h == 8'h00)
            return 8'h12;
        else if (h >= 8'h20)
            return (h[3:0] < 4'd2) ? {4'h0, h[3:0] + 4'd8} : {4'h1, h[3:0] - 4'd2};
        else if (h >= 8'h13)
            return h - 8'h12;
        else
            return h;
    endfunction

    assign w_hh = {w_hhmm.h_ms, w_hhmm.h_ls};

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_time_out <= '0;
            r_sec_out  <= 8'h00;
            r_pm       <= 1'b0;
        end else begin
            r_time_out <= {hour12(w_hh), w_hhmm.m_ms, w_hhmm.m_ls};
            r_sec_out  <= w_sec;
            r_pm       <= (w_hh >= 8'h12);
        end
    end

    assign time_bcd = r_time_out;
    assign sec_bcd  = r_sec_out;
    assign pm       = r_pm;
`else
    assign time_bcd = w_hhmm;
    assign sec_bcd  = w_sec;
    assign pm       = 1'b0;
`endif

endmodule

// File: tb/tb_al_alarm_core.sv
// Bench for al_alarm_core: seconds-of-day reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_al_alarm_core;

    localparam int N   = 3;
    localparam int SNZ = 9;
    localparam int RNG = 5;

    logic          mclk = 1'b0;
    logic          rst = 1'b1;
    logic          sec_tick = 1'b0;
    logic          set_time = 1'b0;
    logic          set_alarm = 1'b0;
    logic [1:0]    set_sel = 2'd0;
    logic [15:0]   set_value = 16'h0000;
    logic [N-1:0]  alarm_en = '0;
    logic          snooze = 1'b0;
    logic          alarm_off = 1'b0;
    logic [15:0]   time_bcd;
    logic [7:0]    sec_bcd;
    logic          pm;
    logic          ringing;
    logic [N-1:0]  ring_src;
    logic          set_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 mclk = ~mclk;

    al_alarm_core #(.NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_MIN(RNG)) dut (
        .mclk(mclk), .rst(rst), .sec_tick(sec_tick), .set_time(set_time),
        .set_alarm(set_alarm), .set_sel(set_sel), .set_value(set_value),
        .alarm_en(alarm_en), .snooze(snooze), .alarm_off(alarm_off),
        .time_bcd(time_bcd), .sec_bcd(sec_bcd), .pm(pm), .ringing(ringing),
        .ring_src(ring_src), .set_err(set_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_tod;          // seconds since midnight
    int          m_alarm [N];    // minutes since midnight
    int          m_mode;         // 0 idle, 1 ringing, 2 snoozed
    int          m_src;
    int          m_mins;         // minute boundaries seen in current ring/snooze
    bit          m_edge;
    bit          m_live = 1'b0;
    logic [15:0] e_time;
    logic [7:0]  e_sec;
    logic        e_pm;
    logic        e_err;

    function automatic logic [7:0] bcd2(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int hhmm_to_min(input logic [15:0] v);
        int d3, d2, d1, d0, h, m;
        d3 = int'(v[15:12]); d2 = int'(v[11:8]); d1 = int'(v[7:4]); d0 = int'(v[3:0]);
        if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return -1;
        h = d3 * 10 + d2;
        m = d1 * 10 + d0;
        if (h > 23 || m > 59) return -1;
        return h * 60 + m;
    endfunction

    function automatic logic [15:0] show_time(input int tod);
        int h;
        h = tod / 3600;
`ifdef AL_HOUR12_EN
        h = (h % 12 == 0) ? 12 : h % 12;
`endif
        return {bcd2(h), bcd2((tod / 60) % 60)};
    endfunction

    always @(posedge mclk) begin
        int tv;
        int pre_tod;
        tv = hhmm_to_min(set_value);
        pre_tod = m_tod;
        if (rst) begin
            m_tod = 0; m_mode = 0; m_src = 0; m_mins = 0; m_edge = 0;
            for (int i = 0; i < N; i++) m_alarm[i] = 0;
            e_time = 16'h0000; e_sec = 8'h00; e_pm = 1'b0; e_err = 1'b0;
            m_live = 1'b1;
        end else begin
            case (m_mode)
                0: if (m_edge) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (alarm_en[i] && m_alarm[i] * 60 == m_tod) begin
                            m_mode = 1; m_src = i; m_mins = 0;
                        end
                end
                1: if (!alarm_en[m_src] || alarm_off) m_mode = 0;
                   else if (snooze) begin m_mode = 2; m_mins = 0; end
                   else if (m_edge) begin
                       m_mins++;
                       if (m_mins == RNG) m_mode = 0;
                   end
                default: if (!alarm_en[m_src] || alarm_off) m_mode = 0;
                   else if (m_edge) begin
                       m_mins++;
                       if (m_mins == SNZ) begin m_mode = 1; m_mins = 0; end
                   end
            endcase
            e_err = (set_time && tv < 0) || (set_alarm && (tv < 0 || int'(set_sel) >= N));
            if (set_alarm && tv >= 0 && int'(set_sel) < N) m_alarm[set_sel] = tv;
            m_edge = 0;
            if (set_time) begin
                if (tv >= 0) m_tod = tv * 60;
            end else if (sec_tick) begin
                m_tod = (m_tod + 1) % 86400;
                m_edge = (m_tod % 60 == 0);
            end
`ifdef AL_HOUR12_EN
            e_time = show_time(pre_tod); e_sec = bcd2(pre_tod % 60); e_pm = (pre_tod >= 12 * 3600);
`else
            e_time = show_time(m_tod); e_sec = bcd2(m_tod % 60); e_pm = 1'b0;
`endif
        end
    end

    always @(negedge mclk) begin
        if (m_live) begin
            chk("time_bcd", 32'(time_bcd), 32'(e_time));
            chk("sec_bcd", 32'(sec_bcd), 32'(e_sec));
            chk("pm", 32'(pm), 32'(e_pm));
            chk("ringing", 32'(ringing), 32'(m_mode == 1));
            chk("ring_src", 32'(ring_src), (m_mode == 0) ? 32'd0 : (32'd1 << m_src));
            chk("set_err", 32'(set_err), 32'(e_err));
        end
    end

    // ---------------- stimulus ----------------
`ifdef AL_HOUR12_EN
    localparam logic [15:0] MIDNIGHT = 16'h1200;
    localparam logic [15:0] LAST_MIN = 16'h1159;
`else
    localparam logic [15:0] MIDNIGHT = 16'h0000;
    localparam logic [15:0] LAST_MIN = 16'h2359;
`endif

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic ticks(input int n);
        @(negedge mclk);
        sec_tick = 1'b1;
        repeat (n) @(negedge mclk);
        sec_tick = 1'b0;
        $display("[%0t] %0d ticks -> %h:%h", $time, n, time_bcd, sec_bcd);
    endtask

    task automatic do_set_time(input logic [15:0] v, input logic with_tick);
        @(negedge mclk);
        set_time = 1'b1; set_value = v; sec_tick = with_tick;
        @(negedge mclk);
        set_time = 1'b0; sec_tick = 1'b0;
        $display("[%0t] set_time %h tick=%0b err=%0b", $time, v, with_tick, set_err);
    endtask

    task automatic do_set_alarm(input logic [1:0] sel, input logic [15:0] v);
        @(negedge mclk);
        set_alarm = 1'b1; set_sel = sel; set_value = v;
        @(negedge mclk);
        set_alarm = 1'b0;
        $display("[%0t] set_alarm[%0d] %h err=%0b", $time, sel, v, set_err);
    endtask

    task automatic press(input bit is_off);
        @(negedge mclk);
        if (is_off) alarm_off = 1'b1; else snooze = 1'b1;
        @(negedge mclk);
        alarm_off = 1'b0; snooze = 1'b0;
        $display("[%0t] %s -> ringing=%0b src=%b", $time, is_off ? "alarm_off" : "snooze", ringing, ring_src);
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        chk("reset time", 32'(time_bcd), 32'h0000);
        chk("reset ringing", 32'(ringing), 32'd0);

        // Seconds, minute and hour wraps, then midnight.
        ticks(3700); cyc(1);
        chk("01:01:40 time", 32'(time_bcd), 32'h0101);
        chk("01:01:40 sec", 32'(sec_bcd), 32'h40);
        do_set_time(16'h2359, 1'b0);
        ticks(59); cyc(1);
        chk("23:59:59 time", 32'(time_bcd), 32'(LAST_MIN));
        chk("23:59:59 sec", 32'(sec_bcd), 32'h59);
        ticks(1); cyc(1);
        chk("midnight time", 32'(time_bcd), 32'(MIDNIGHT));
        chk("midnight sec", 32'(sec_bcd), 32'h00);

        // Alarm 1 at 06:30, snooze, re-ring after 9 minutes, then off.
        do_set_alarm(2'd1, 16'h0630);
        chk("valid set_alarm err", 32'(set_err), 32'd0);
        alarm_en = 3'b010;
        do_set_time(16'h0629, 1'b0);
        ticks(60);
        chk("ring latency", 32'(ringing), 32'd0);
        cyc(1);
        chk("ring at 06:30", 32'(ringing), 32'd1);
        chk("ring_src 06:30", 32'(ring_src), 32'b010);
        press(1'b0);
        chk("snoozed", 32'(ringing), 32'd0);
        ticks(539); cyc(1);
        chk("still snoozed 06:38:59", 32'(ringing), 32'd0);
        ticks(1); cyc(1);
        chk("re-ring 06:39", 32'(ringing), 32'd1);
        chk("re-ring time", 32'(time_bcd), 32'h0639);
        press(1'b1);
        chk("off ringing", 32'(ringing), 32'd0);
        chk("off ring_src", 32'(ring_src), 32'd0);

        // Unacknowledged ring times out after 5 minutes.
        do_set_time(16'h0629, 1'b0);
        ticks(60); cyc(1);
        chk("ring again", 32'(ringing), 32'd1);
        ticks(240); cyc(1);
        chk("ring 06:34", 32'(ringing), 32'd1);
        ticks(60); cyc(1);
        chk("auto-off 06:35", 32'(ringing), 32'd0);

        // Loading the alarm time directly must not ring.
        do_set_time(16'h0630, 1'b0);
        ticks(30); cyc(1);
        chk("no ring on set_time", 32'(ringing), 32'd0);

        // Rejected requests.
        do_set_time(16'h2460, 1'b0);
        chk("err 2460", 32'(set_err), 32'd1);
        cyc(1);
        chk("err pulse width", 32'(set_err), 32'd0);
        chk("time kept", 32'(time_bcd), 32'h0630);
        chk("sec kept", 32'(sec_bcd), 32'h30);
        do_set_time(16'h0970, 1'b0);
        chk("err 0970", 32'(set_err), 32'd1);
        do_set_alarm(2'd3, 16'h0100);
        chk("err sel 3", 32'(set_err), 32'd1);
        do_set_alarm(2'd1, 16'h0970);
        chk("err alarm 0970", 32'(set_err), 32'd1);
        do_set_time(16'h0629, 1'b0);
        ticks(60); cyc(1);
        chk("alarm1 kept", 32'(ring_src), 32'b010);
        press(1'b1);

        // set_time beats a coincident tick.
        do_set_time(16'h1000, 1'b1);
        cyc(1);
        chk("tick dropped time", 32'(time_bcd), 32'h1000);
        chk("tick dropped sec", 32'(sec_bcd), 32'h00);

        // Lowest index wins; dropping its enable cancels.
        do_set_alarm(2'd0, 16'h0700);
        do_set_alarm(2'd1, 16'h0700);
        alarm_en = 3'b011;
        do_set_time(16'h0659, 1'b0);
        ticks(60); cyc(1);
        chk("lowest wins", 32'(ring_src), 32'b001);
        @(negedge mclk); alarm_en = 3'b010;
        cyc(1);
        chk("en drop ringing", 32'(ringing), 32'd0);
        chk("en drop src", 32'(ring_src), 32'd0);

        // Reset mid-ring.
        alarm_en = 3'b011;
        do_set_time(16'h0659, 1'b0);
        ticks(60); cyc(1);
        chk("ring before rst", 32'(ringing), 32'd1);
        @(negedge mclk); rst = 1'b1;
        @(negedge mclk); rst = 1'b0;
        chk("rst mid-ring", 32'(ringing), 32'd0);
        chk("rst time", 32'(time_bcd), 32'h0000);
        press(1'b0);
        chk("snooze idle", 32'(ringing), 32'd0);

`ifdef AL_HOUR12_EN
        do_set_time(16'h0000, 1'b0); cyc(1);
        chk("12h midnight", 32'(time_bcd), 32'h1200);
        chk("12h am", 32'(pm), 32'd0);
        do_set_time(16'h1345, 1'b0); cyc(1);
        chk("12h 13:45", 32'(time_bcd), 32'h0145);
        chk("12h pm", 32'(pm), 32'd1);
        alarm_en = 3'b001;
        do_set_alarm(2'd0, 16'h1346);
        ticks(60); cyc(1);
        chk("12h match 24h alarm", 32'(ringing), 32'd1);
`endif

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
